// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Operands ex_a/ex_b/ex_store_data are resolved combinationally from the stage register.
module id_ex_operand_stage #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [14:0]       id_regs,
  input  logic [4:0]        id_alu_control,
  input  logic [5:0]        id_ctrl,
  input  logic              exm_reg_write,
  input  logic [4:0]        exm_write_reg,
  input  logic [DATA_W-1:0] exm_alu_result,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              ex_valid,
  output logic [4:0]        ex_alu_control,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [4:0]        ex_write_reg,
  output logic [2:0]        ex_ctrl,
  output logic              hazard_stall
);

  logic              vld_p0;
  logic [4:0]        alu_ctrl_p0;
  logic              alu_src_p0;
  logic              shift_p0;
  logic [2:0]        ctrl_p0;
  logic [4:0]        wreg_p0;
  logic [4:0]        rs_p0;
  logic [4:0]        rt_p0;
  logic [DATA_W-1:0] rs_data_p0;
  logic [DATA_W-1:0] rt_data_p0;
  logic [DATA_W-1:0] imm_p0;

  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic              load_bubble;
  logic              advance;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // EX/MEM has priority over MEM/WB; r0 is hardwired and never forwarded.
  function automatic logic [DATA_W-1:0] forward(
    input logic [4:0]        src,
    input logic [DATA_W-1:0] stored,
    input logic              m_we,
    input logic [4:0]        m_reg,
    input logic [DATA_W-1:0] m_val,
    input logic              w_we,
    input logic [4:0]        w_reg,
    input logic [DATA_W-1:0] w_val
  );
    if (m_we && (m_reg != 5'd0) && (m_reg == src))
      return m_val;
    else if (w_we && (w_reg != 5'd0) && (w_reg == src))
      return w_val;
    else
      return stored;
  endfunction

  assign id_rs = id_regs[14:10];
  assign id_rt = id_regs[9:5];
  assign id_rd = id_regs[4:0];

  assign hazard_stall = vld_p0 && ctrl_p0[1] && (wreg_p0 != 5'd0) && id_valid &&
                        ((wreg_p0 == id_rs) || (wreg_p0 == id_rt)) && !stall;

  assign advance     = flush || !stall;
  assign load_bubble = flush || hazard_stall || !id_valid;

  // ---- ID -> EX stage register ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p0      <= 1'b0;
      alu_ctrl_p0 <= '0;
      alu_src_p0  <= 1'b0;
      shift_p0    <= 1'b0;
      ctrl_p0     <= '0;
      wreg_p0     <= '0;
      rs_p0       <= '0;
      rt_p0       <= '0;
      rs_data_p0  <= '0;
      rt_data_p0  <= '0;
      imm_p0      <= '0;
    end else if (advance) begin
      vld_p0      <= !load_bubble;
      alu_ctrl_p0 <= load_bubble ? 5'd0 : id_alu_control;
      alu_src_p0  <= load_bubble ? 1'b0 : id_ctrl[5];
      shift_p0    <= load_bubble ? 1'b0 : id_ctrl[4];
      ctrl_p0     <= load_bubble ? 3'd0 : id_ctrl[2:0];
      wreg_p0     <= load_bubble ? 5'd0 : (id_ctrl[3] ? id_rd : id_rt);
      rs_p0       <= id_rs;
      rt_p0       <= id_rt;
      rs_data_p0  <= id_rs_data;
      rt_data_p0  <= id_rt_data;
      imm_p0      <= id_imm;
    end
  end

  // ---- EX operand selection ----
  assign fwd_rs = forward(rs_p0, rs_data_p0, exm_reg_write, exm_write_reg, exm_alu_result,
                          wb_reg_write, wb_write_reg, wb_write_data);
  assign fwd_rt = forward(rt_p0, rt_data_p0, exm_reg_write, exm_write_reg, exm_alu_result,
                          wb_reg_write, wb_write_reg, wb_write_data);

  assign ex_valid       = vld_p0;
  assign ex_alu_control = alu_ctrl_p0;
  assign ex_ctrl        = ctrl_p0;
  assign ex_write_reg   = wreg_p0;
  assign ex_a           = shift_p0 ? imm_p0 : fwd_rs;
  assign ex_b           = alu_src_p0 ? imm_p0 : fwd_rt;
  assign ex_store_data  = fwd_rt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus a randomized run against a slot-level model.
module tb_id_ex_operand_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [14:0] id_regs;
  logic [4:0]  id_alu_control;
  logic [5:0]  id_ctrl;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_write_reg, wb_write_reg;
  logic [31:0] exm_alu_result, wb_write_data;
  logic        ex_valid, hazard_stall;
  logic [4:0]  ex_alu_control, ex_write_reg;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [2:0]  ex_ctrl;

  int tests = 0;
  int fails = 0;

  id_ex_operand_stage dut (
    .Clk(Clk), .Reset(Reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_regs(id_regs),
    .id_alu_control(id_alu_control), .id_ctrl(id_ctrl),
    .exm_reg_write(exm_reg_write), .exm_write_reg(exm_write_reg), .exm_alu_result(exm_alu_result),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .ex_valid(ex_valid), .ex_alu_control(ex_alu_control), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_ctrl(ex_ctrl),
    .hazard_stall(hazard_stall)
  );

  always #5 Clk = ~Clk;

  // Instruction currently held in the EX slot, as the model sees it.
  typedef struct {
    bit        v;
    bit [4:0]  alu;
    bit        alu_src, shift, rw, mr, mw;
    bit [4:0]  rs, rt, dst;
    bit [31:0] rsd, rtd, imm;
  } slot_t;

  slot_t ex;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_regs = 0;
    id_alu_control = 0; id_ctrl = 0;
    exm_reg_write = 0; exm_write_reg = 0; exm_alu_result = 0;
    wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                        input bit [31:0] rsd, input bit [31:0] rtd, input bit [31:0] imm,
                        input bit [4:0] alu, input bit [5:0] ctrl);
    id_valid = v; id_regs = {rs, rt, rd};
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alu_control = alu; id_ctrl = ctrl;
  endtask

  task automatic do_reset();
    Reset = 1; #3; Reset = 0; #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1;
    #2;
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
    tests++; if (ex_ctrl !== 3'b000) begin fails++; $display("FAIL reset_ctrl got %b want 000", ex_ctrl); end
    tests++; if (ex_alu_control !== 5'd0) begin fails++; $display("FAIL reset_alu got %b want 00000", ex_alu_control); end
    tests++; if (ex_write_reg !== 5'd0) begin fails++; $display("FAIL reset_wreg got %0d want 0", ex_write_reg); end
    tests++; if (ex_a !== 32'd0 || ex_b !== 32'd0) begin fails++; $display("FAIL reset_operands got a=%h b=%h want 0", ex_a, ex_b); end
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL reset_hazard got %0b want 0", hazard_stall); end
    tick(); tick();
    Reset = 0;
    tick();
  endtask

  task automatic test_add();
    idle_inputs();
    set_id(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0000_1820, 5'b00001, 6'b001100);
    tick();
    id_valid = 0;
    #1;
    tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %0b want 1", ex_valid); end
    tests++; if (ex_a !== 32'd5) begin fails++; $display("FAIL add_a got %0d want 5", ex_a); end
    tests++; if (ex_b !== 32'd7) begin fails++; $display("FAIL add_b got %0d want 7", ex_b); end
    tests++; if (ex_write_reg !== 5'd3) begin fails++; $display("FAIL add_wreg got %0d want 3", ex_write_reg); end
    tests++; if (ex_ctrl !== 3'b100) begin fails++; $display("FAIL add_ctrl got %b want 100", ex_ctrl); end
    tests++; if (ex_alu_control !== 5'b00001) begin fails++; $display("FAIL add_alu got %b want 00001", ex_alu_control); end
    tick();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL add_idle_bubble got %0b want 0", ex_valid); end
  endtask

  task automatic test_sll();
    logic [31:0] a;
    idle_inputs();
    set_id(1, 5'd0, 5'd2, 5'd4, 32'hDEAD_0000, 32'h0000_1234, 32'h0000_00C0, 5'b00100, 6'b011100);
    tick();
    id_valid = 0;
    #1;
    a = ex_a;
    tests++; if (a[10:6] !== 5'd3) begin fails++; $display("FAIL sll_shamt got %0d want 3", a[10:6]); end
    tests++; if (ex_b !== 32'h0000_1234) begin fails++; $display("FAIL sll_b got %h want 00001234", ex_b); end
    tests++; if (ex_alu_control !== 5'b00100) begin fails++; $display("FAIL sll_alu got %b want 00100", ex_alu_control); end
    tests++; if (ex_write_reg !== 5'd4) begin fails++; $display("FAIL sll_wreg got %0d want 4", ex_write_reg); end
  endtask

  task automatic test_forwarding();
    idle_inputs();
    set_id(1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 5'b00001, 6'b001100);
    tick();
    id_valid = 0;
    exm_reg_write = 1; exm_write_reg = 5'd1; exm_alu_result = 32'hAA;
    wb_reg_write = 1; wb_write_reg = 5'd1; wb_write_data = 32'hBB;
    #1;
    tests++; if (ex_a !== 32'hAA) begin fails++; $display("FAIL fwd_exm_wins got %h want aa", ex_a); end
    tests++; if (ex_b !== 32'h22) begin fails++; $display("FAIL fwd_rt_none got %h want 22", ex_b); end
    exm_write_reg = 5'd0; wb_write_reg = 5'd2;
    #1;
    tests++; if (ex_a !== 32'h11) begin fails++; $display("FAIL fwd_rs_stored got %h want 11", ex_a); end
    tests++; if (ex_store_data !== 32'hBB) begin fails++; $display("FAIL fwd_wb_store got %h want bb", ex_store_data); end
    wb_write_reg = 5'd1;
    #1;
    tests++; if (ex_a !== 32'hBB) begin fails++; $display("FAIL fwd_wb_rs got %h want bb", ex_a); end
    // Instruction reading r0: neither source may forward.
    set_id(1, 5'd0, 5'd0, 5'd3, 32'h55, 32'h66, 32'h0, 5'b00001, 6'b001100);
    exm_write_reg = 5'd1;
    tick();
    id_valid = 0; exm_write_reg = 5'd0; wb_write_reg = 5'd0;
    #1;
    tests++; if (ex_a !== 32'h55) begin fails++; $display("FAIL fwd_r0_rs got %h want 55", ex_a); end
    tests++; if (ex_store_data !== 32'h66) begin fails++; $display("FAIL fwd_r0_rt got %h want 66", ex_store_data); end
  endtask

  task automatic test_load_use();
    idle_inputs();
    set_id(1, 5'd1, 5'd5, 5'd0, 32'h100, 32'h0, 32'h4, 5'b00001, 6'b100110);
    tick();
    set_id(1, 5'd5, 5'd2, 5'd6, 32'h1, 32'h2, 32'h0, 5'b00001, 6'b001100);
    #1;
    tests++; if (hazard_stall !== 1'b1) begin fails++; $display("FAIL lu_hazard got %0b want 1", hazard_stall); end
    tick();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble got %0b want 0", ex_valid); end
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL lu_hazard_clear got %0b want 0", hazard_stall); end
    tick();
    id_valid = 0;
    #1;
    tests++; if (ex_valid !== 1'b1 || ex_write_reg !== 5'd6) begin fails++; $display("FAIL lu_capture got v=%0b wr=%0d want v=1 wr=6", ex_valid, ex_write_reg); end
    tick();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL lu_once got %0b want 0", ex_valid); end
    // Stall masks the hazard; reset mid-hazard discards everything.
    set_id(1, 5'd1, 5'd5, 5'd0, 32'h100, 32'h0, 32'h4, 5'b00001, 6'b100110);
    tick();
    set_id(1, 5'd2, 5'd5, 5'd7, 32'h1, 32'h2, 32'h0, 5'b00001, 6'b001100);
    stall = 1;
    #1;
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL lu_stall_mask got %0b want 0", hazard_stall); end
    stall = 0;
    #1;
    tests++; if (hazard_stall !== 1'b1) begin fails++; $display("FAIL lu_hazard_rt got %0b want 1", hazard_stall); end
    do_reset();
    tests++; if (ex_valid !== 1'b0 || hazard_stall !== 1'b0) begin fails++; $display("FAIL lu_reset got v=%0b hz=%0b want 0 0", ex_valid, hazard_stall); end
    tick();
    id_valid = 0;
    #1;
    tests++; if (ex_valid !== 1'b1 || ex_write_reg !== 5'd7) begin fails++; $display("FAIL lu_post_reset got v=%0b wr=%0d want v=1 wr=7", ex_valid, ex_write_reg); end
  endtask

  task automatic test_stall_flush();
    idle_inputs();
    set_id(1, 5'd1, 5'd2, 5'd9, 32'h5, 32'h7, 32'h0, 5'b00001, 6'b001100);
    tick();
    set_id(1, 5'd3, 5'd4, 5'd10, 32'h8, 32'h9, 32'h0, 5'b00010, 6'b001100);
    stall = 1;
    tick();
    tests++; if (ex_write_reg !== 5'd9 || ex_a !== 32'h5) begin fails++; $display("FAIL stall_hold got wr=%0d a=%h want wr=9 a=5", ex_write_reg, ex_a); end
    flush = 1;
    tick();
    tests++; if (ex_valid !== 1'b0 || ex_ctrl !== 3'b000 || ex_write_reg !== 5'd0) begin fails++; $display("FAIL stall_flush got v=%0b c=%b wr=%0d want 0", ex_valid, ex_ctrl, ex_write_reg); end
    stall = 0; flush = 0;
    // Flush together with a load-use hazard gives one bubble only.
    set_id(1, 5'd1, 5'd5, 5'd0, 32'h100, 32'h0, 32'h4, 5'b00001, 6'b100110);
    tick();
    set_id(1, 5'd5, 5'd2, 5'd6, 32'h1, 32'h2, 32'h0, 5'b00001, 6'b001100);
    flush = 1;
    tick();
    flush = 0;
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL flush_hz_bubble got %0b want 0", ex_valid); end
    tick();
    id_valid = 0;
    #1;
    tests++; if (ex_valid !== 1'b1 || ex_write_reg !== 5'd6) begin fails++; $display("FAIL flush_hz_next got v=%0b wr=%0d want v=1 wr=6", ex_valid, ex_write_reg); end
    // Asynchronous reset pulse between clock edges.
    set_id(1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 5'b00101, 6'b001111);
    tick();
    id_valid = 0;
    Reset = 1;
    #1;
    tests++; if (ex_valid !== 1'b0 || ex_ctrl !== 3'b000 || ex_alu_control !== 5'd0 || ex_write_reg !== 5'd0) begin
      fails++; $display("FAIL async_reset got v=%0b c=%b alu=%b wr=%0d want 0", ex_valid, ex_ctrl, ex_alu_control, ex_write_reg);
    end
    Reset = 0;
    #1;
  endtask

  function automatic bit [31:0] model_fwd(input bit [4:0] r, input bit [31:0] stored);
    if (exm_reg_write && exm_write_reg != 0 && exm_write_reg == r) return exm_alu_result;
    if (wb_reg_write && wb_write_reg != 0 && wb_write_reg == r) return wb_write_data;
    return stored;
  endfunction

  task automatic test_random();
    slot_t bubble, nxt;
    bit    hz;
    bit [31:0] ea, eb, es;
    bit [4:0] rs, rt, rd;
    bubble = '{default: 0};
    idle_inputs();
    do_reset();
    ex = bubble;
    for (int i = 0; i < 400; i++) begin
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      set_id($urandom_range(0, 3) != 0, rs, rt, rd, $urandom, $urandom, $urandom,
             5'($urandom_range(0, 14)), 6'($urandom));
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      exm_reg_write = $urandom_range(0, 1); exm_write_reg = 5'($urandom_range(0, 3)); exm_alu_result = $urandom;
      wb_reg_write = $urandom_range(0, 1); wb_write_reg = 5'($urandom_range(0, 3)); wb_write_data = $urandom;
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
        ex = bubble;
      end
      #2;
      hz = ex.v && ex.mr && ex.dst != 0 && id_valid && (ex.dst == rs || ex.dst == rt) && !stall;
      tests++; if (hazard_stall !== hz) begin fails++; $display("FAIL rnd_hazard[%0d] got %0b want %0b", i, hazard_stall, hz); end
      tests++; if (ex_valid !== ex.v || ex_alu_control !== ex.alu || ex_ctrl !== {ex.rw, ex.mr, ex.mw} || ex_write_reg !== ex.dst) begin
        fails++; $display("FAIL rnd_ctrl[%0d] got v=%0b alu=%0d c=%b wr=%0d want v=%0b alu=%0d c=%b wr=%0d",
                          i, ex_valid, ex_alu_control, ex_ctrl, ex_write_reg, ex.v, ex.alu, {ex.rw, ex.mr, ex.mw}, ex.dst);
      end
      if (ex.v) begin
        es = model_fwd(ex.rt, ex.rtd);
        ea = ex.shift ? ex.imm : model_fwd(ex.rs, ex.rsd);
        eb = ex.alu_src ? ex.imm : es;
        tests++; if (ex_a !== ea || ex_b !== eb || ex_store_data !== es) begin
          fails++; $display("FAIL rnd_operands[%0d] got a=%h b=%h s=%h want a=%h b=%h s=%h", i, ex_a, ex_b, ex_store_data, ea, eb, es);
        end
      end
      if (flush || (!stall && (hz || !id_valid))) nxt = bubble;
      else if (stall) nxt = ex;
      else begin
        nxt.v = 1; nxt.alu = id_alu_control;
        {nxt.alu_src, nxt.shift} = id_ctrl[5:4];
        {nxt.rw, nxt.mr, nxt.mw} = id_ctrl[2:0];
        nxt.rs = rs; nxt.rt = rt; nxt.dst = id_ctrl[3] ? rd : rt;
        nxt.rsd = id_rs_data; nxt.rtd = id_rt_data; nxt.imm = id_imm;
      end
      tick();
      ex = nxt;
    end
  endtask

  initial begin
    Reset = 0;
    idle_inputs();
    test_reset();
    test_add();
    test_sll();
    test_forwarding();
    test_load_use();
    test_stall_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset; all state SHALL be captured on the rising edge of Clk.
REQ-002 Clk  in  1  rising-edge clock.
REQ-003 Reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 stall  in  1  hold the stage register unchanged.
REQ-005 flush  in  1  load a bubble on the next edge; overrides stall.
REQ-006 id_valid  in  1  ID slot holds a real instruction.
REQ-007 id_rs_data  in  32  register-file rs read value.
REQ-008 id_rt_data  in  32  register-file rt read value.
REQ-009 id_imm  in  32  sign-extended instruction[15:0]; bits 10:6 carry shamt.
REQ-010 id_regs  in  15  {rs[14:10], rt[9:5], rd[4:0]}.
REQ-011 id_alu_control  in  5  ALU operation code (ALU encoding: 00001 add ... 01110 slt; 00000 yields result 0).
REQ-012 id_ctrl  in  6  {alu_src, shift, reg_dst, reg_write, mem_read, mem_write}.
REQ-013 exm_reg_write / exm_write_reg / exm_alu_result  in  1/5/32  EX/MEM forwarding source (three ports).
REQ-014 wb_reg_write / wb_write_reg / wb_write_data  in  1/5/32  MEM/WB forwarding source (three ports).
REQ-015 ex_valid  out  1  EX slot holds a real instruction.
REQ-016 ex_alu_control  out  5  registered ALU code to the ALU.
REQ-017 ex_a  out  32  ALU operand A (combinational from stage register plus forwarding).
REQ-018 ex_b  out  32  ALU operand B (combinational).
REQ-019 ex_store_data  out  32  forwarded rt value for sw.
REQ-020 ex_write_reg  out  5  destination register.
REQ-021 ex_ctrl  out  3  {reg_write, mem_read, mem_write}.
REQ-022 hazard_stall  out  1  load-use hazard; ID/IF must hold this cycle.

Function
REQ-023 Edge priority SHALL be Reset > flush > stall (hold) > hazard_stall (load bubble) > capture of ID fields.
REQ-024 A bubble SHALL set ex_valid=0, ex_alu_control=00000, ex_ctrl=000, ex_write_reg=0; data fields are don't-care.
REQ-025 Capture with id_valid=0 SHALL produce a bubble.
REQ-026 ex_write_reg SHALL be captured as rd when reg_dst=1, else rt.
REQ-027 hazard_stall SHALL be 1 iff ex_valid & ex mem_read & ex_write_reg!=0 & id_valid & (ex_write_reg==rs | ex_write_reg==rt); combinational, 0 during stall.
REQ-028 fwd_rs SHALL be exm_alu_result if exm_reg_write & exm_write_reg!=0 & exm_write_reg==stored rs; else wb_write_data if same test on WB; else stored rs_data; fwd_rt likewise.
REQ-029 EX/MEM match SHALL win over MEM/WB match; register 0 SHALL never be forwarded.
REQ-030 ex_a SHALL be stored imm when stored shift=1 (so ALU reads A[10:6] as shamt), else fwd_rs.
REQ-031 ex_b SHALL be stored imm when stored alu_src=1, else fwd_rt; ex_store_data SHALL always be fwd_rt.
REQ-032 Latency SHALL be one cycle ID to EX; forwarding adds zero cycles.
REQ-033 flush and hazard asserted together SHALL yield a single bubble, no duplicate.

Reset
REQ-034 On Reset all outputs SHALL be 0 (ex_valid=0, ex_ctrl=000, ex_alu_control=00000, ex_write_reg=0) regardless of Clk.
REQ-035 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction; first capture after release SHALL be a normal load.

Verification
REQ-036 add r3,r1,r2 (rs_data=5, rt_data=7), no forwarding -> next cycle ex_a=5, ex_b=7, ex_write_reg=3, ex_ctrl=100, ex_valid=1.
REQ-037 sll r4,r2,3 (imm=0x000000C0) -> ex_a[10:6]=3, ex_b=rt_data, ex_alu_control=00100.
REQ-038 EX stored rs=1; exm r1=0xAA and wb r1=0xBB both valid -> ex_a=0xAA; with exm_write_reg=0 targeting r0 -> stored data.
REQ-039 lw r5 in EX, ID add uses r5 -> hazard_stall=1, next edge ex_valid=0, following edge add captured once.
REQ-040 stall=1 and flush=1 same edge -> bubble; Reset pulse between edges -> all outputs 0 immediately.
